// File: rtl/cmd_sender.sv
// Streams CR/LF-terminated BLE commands from the command register file into the TX FIFO.
// Sends one selected command, or all stored commands with an idle gap between them.
module cmd_sender #(
  parameter int unsigned CMD_WIDTH  = 32,
  parameter int unsigned CMD_DEPTH  = 16,
  parameter int unsigned GAP_CYCLES = 1000,
  localparam int unsigned ADDR_W = $clog2(CMD_DEPTH * CMD_WIDTH),
  localparam int unsigned IDX_W  = $clog2(CMD_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              send_all,
  input  logic [IDX_W-1:0]  cmd_idx,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error_code,
  output logic              error_pulse
);

  localparam int unsigned BYTE_W = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [1:0] ERR_IDX     = 2'd1;
  localparam logic [1:0] ERR_NO_TERM = 2'd2;
  localparam logic [1:0] ERR_EMPTY   = 2'd3;

  typedef enum logic [3:0] {
    IDLE, RD_CNT, WT_CNT, CHECK, RD_BYTE, WT_BYTE, PUSH, GAP, FINISH
  } state_t;

  state_t            state;
  logic              all_mode;
  logic [IDX_W-1:0]  cur_idx;
  logic [7:0]        count;
  logic [BYTE_W-1:0] byte_idx;
  logic [GAP_W-1:0]  gap_cnt;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0]  idx,
                                                  input logic [BYTE_W-1:0] bidx);
    return ADDR_W'(1) + ADDR_W'(idx) * ADDR_W'(CMD_WIDTH) + ADDR_W'(bidx);
  endfunction

  // Write strobe is gated by the live full flag so no byte is ever offered to a full FIFO.
  assign tx_wr_en = (state == PUSH) && !tx_full;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      all_mode    <= 1'b0;
      cur_idx     <= '0;
      count       <= '0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      tx_data     <= '0;
      done        <= 1'b0;
      error_code  <= 2'd0;
      error_pulse <= 1'b0;
    end else begin
      mem_rd_en   <= 1'b0;
      done        <= 1'b0;
      error_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start || send_all) begin
            cur_idx   <= start ? cmd_idx : '0;
            all_mode  <= !start;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            state     <= RD_CNT;
          end
        end
        RD_CNT: state <= WT_CNT;
        WT_CNT: begin
          count <= mem_rdata;
          state <= CHECK;
        end
        CHECK: begin
          if (all_mode && count == 8'd0) begin
            error_code  <= ERR_EMPTY;
            error_pulse <= 1'b1;
            state       <= IDLE;
          end else if (8'(cur_idx) >= count || cur_idx >= IDX_W'(CMD_DEPTH - 1)) begin
            error_code  <= ERR_IDX;
            error_pulse <= 1'b1;
            state       <= IDLE;
          end else begin
            byte_idx  <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= slot_addr(cur_idx, '0);
            state     <= RD_BYTE;
          end
        end
        RD_BYTE: state <= WT_BYTE;
        WT_BYTE: begin
          tx_data <= mem_rdata;
          state   <= PUSH;
        end
        PUSH: begin
          if (!tx_full) begin
            if (tx_data == LF) begin
              if (all_mode && (9'(cur_idx) + 9'd1) < 9'(count)) begin
                cur_idx <= cur_idx + IDX_W'(1);
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                done  <= 1'b1;
                state <= FINISH;
              end
            end else if (byte_idx == BYTE_W'(CMD_WIDTH - 1)) begin
              error_code  <= ERR_NO_TERM;
              error_pulse <= 1'b1;
              state       <= IDLE;
            end else begin
              byte_idx  <= byte_idx + BYTE_W'(1);
              mem_rd_en <= 1'b1;
              mem_addr  <= slot_addr(cur_idx, byte_idx + BYTE_W'(1));
              state     <= RD_BYTE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            byte_idx  <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= slot_addr(cur_idx, '0);
            state     <= RD_BYTE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sender.sv
// Scoreboard bench for cmd_sender: expected bytes queued at stimulus, compared against captured writes.
module tb_cmd_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       send_all;
  logic [3:0] cmd_idx;
  logic       mem_rd_en;
  logic [8:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       tx_full;
  logic       tx_wr_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [1:0] error_code;
  logic       error_pulse;

  cmd_sender #(.CMD_WIDTH(32), .CMD_DEPTH(16), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .send_all(send_all), .cmd_idx(cmd_idx),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_data(tx_data), .busy(busy),
    .done(done), .error_code(error_code), .error_pulse(error_pulse)
  );

  always #5 clk = ~clk;

  // Register-file model: data valid the cycle after the read strobe.
  logic [7:0] mem [0:511];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_n = 0;
  int total_n = 0;
  int start_cyc, idle_at, done_n, done_at, err_n;
  bit ok, stall_bad;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
  endtask

  task automatic load_str(input int slot, input string s);
    for (int i = 0; i < s.len(); i++) mem[1 + slot * 32 + i] = s[i];
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic issue(input bit all, input logic [3:0] idx);
    @(negedge clk);
    start = !all; send_all = all; cmd_idx = idx; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; send_all = 1'b0;
  endtask

  // Capture DUT activity each cycle until it returns idle; k counts cycles since the start edge.
  task automatic run(input int budget, input bit stall);
    ok = 0; stall_bad = 0; idle_at = -1; done_n = 0; done_at = -1; err_n = 0;
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < budget; i++) begin
      int k;
      if (i > 0) @(negedge clk);
      k = cyc - start_cyc;
      tx_full = stall && k >= 9 && k < 29;
      #1;
      if (tx_wr_en) begin got_q.push_back(tx_data); got_cyc.push_back(k); end
      if (stall && k >= 9 && k < 29 && (tx_wr_en || tx_data !== 8'h54)) stall_bad = 1;
      if (done) begin done_n++; done_at = k; end
      if (error_pulse) err_n++;
      if (!busy) begin ok = 1; idle_at = k; break; end
    end
    tx_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; send_all = 1'b0; cmd_idx = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_n++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_n++;
    total_n++; if (tx_wr_en !== 1'b0) $display("FAIL reset_wr: got %b expected 0", tx_wr_en); else pass_n++;
    total_n++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd: got %b expected 0", mem_rd_en); else pass_n++;
    total_n++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_n++;
    total_n++; if (error_code !== 2'd0) $display("FAIL reset_err: got %0d expected 0", error_code); else pass_n++;
    total_n++; if (error_pulse !== 1'b0) $display("FAIL reset_epulse: got %b expected 0", error_pulse); else pass_n++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] e, g;
    clear_mem(); mem[0] = 8'd7; load_str(0, "AT\r\n");
    expect_str("AT\r\n");
    issue(0, 4'd0);
    run(200, 0);
    total_n++; if (!ok) $display("FAIL single_timeout: got busy expected idle"); else pass_n++;
    total_n++; if (got_cyc.size() == 0 || got_cyc[0] != 6)
      $display("FAIL single_latency: got %0d writes expected first at cycle 6", got_cyc.size()); else pass_n++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total_n++;
      if (g !== e) $display("FAIL single_byte: got %02h expected %02h", g, e); else pass_n++;
    end
    total_n++; if (got_q.size() + exp_q.size() != 0)
      $display("FAIL single_count: got %0d extra, %0d missing expected 0", got_q.size(), exp_q.size()); else pass_n++;
    exp_q.delete();
    total_n++; if (done_n != 1 || got_cyc.size() != 4 || done_at != got_cyc[3] + 1)
      $display("FAIL single_done: got %0d pulses at %0d expected 1 at %0d", done_n, done_at, 16); else pass_n++;
    total_n++; if (err_n != 0 || error_code !== 2'd0)
      $display("FAIL single_err: got %0d pulses code %0d expected 0", err_n, error_code); else pass_n++;
  endtask

  task automatic test_bad_idx();
    clear_mem(); mem[0] = 8'd7; load_str(0, "AT\r\n");
    issue(0, 4'd7);
    run(50, 0);
    total_n++; if (!ok || idle_at != 4) $display("FAIL idx_idle: got %0d expected 4", idle_at); else pass_n++;
    total_n++; if (err_n != 1) $display("FAIL idx_pulse: got %0d expected 1", err_n); else pass_n++;
    total_n++; if (error_code !== 2'd1) $display("FAIL idx_code: got %0d expected 1", error_code); else pass_n++;
    total_n++; if (got_q.size() != 0 || done_n != 0)
      $display("FAIL idx_quiet: got %0d writes %0d done expected 0", got_q.size(), done_n); else pass_n++;
  endtask

  task automatic test_stall();
    logic [7:0] e, g;
    clear_mem(); mem[0] = 8'd7; load_str(0, "AT\r\n");
    expect_str("AT\r\n");
    issue(0, 4'd0);
    run(200, 1);
    total_n++; if (!ok) $display("FAIL stall_timeout: got busy expected idle"); else pass_n++;
    total_n++; if (stall_bad) $display("FAIL stall_hold: got write or data change expected hold of 54"); else pass_n++;
    total_n++; if (got_cyc.size() < 2 || got_cyc[1] != 29)
      $display("FAIL stall_resume: got %0d writes expected second at cycle 29", got_cyc.size()); else pass_n++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total_n++;
      if (g !== e) $display("FAIL stall_byte: got %02h expected %02h", g, e); else pass_n++;
    end
    total_n++; if (got_q.size() + exp_q.size() != 0)
      $display("FAIL stall_count: got %0d extra, %0d missing expected 0", got_q.size(), exp_q.size()); else pass_n++;
    exp_q.delete();
    total_n++; if (done_n != 1) $display("FAIL stall_done: got %0d expected 1", done_n); else pass_n++;
  endtask

  task automatic test_send_all();
    logic [7:0] e, g;
    clear_mem(); mem[0] = 8'd2; load_str(0, "AT\r\n"); load_str(1, "AT+RESET\r\n");
    expect_str("AT\r\n"); expect_str("AT+RESET\r\n");
    issue(1, 4'd9);
    run(300, 0);
    total_n++; if (!ok) $display("FAIL all_timeout: got busy expected idle"); else pass_n++;
    total_n++; if (got_q.size() != 14) $display("FAIL all_total: got %0d expected 14", got_q.size()); else pass_n++;
    total_n++; if (got_cyc.size() < 5 || got_cyc[4] - got_cyc[3] - 1 < 4)
      $display("FAIL all_gap: got %0d writes expected >=4 idle cycles after first LF", got_cyc.size()); else pass_n++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total_n++;
      if (g !== e) $display("FAIL all_byte: got %02h expected %02h", g, e); else pass_n++;
    end
    total_n++; if (got_q.size() + exp_q.size() != 0)
      $display("FAIL all_count: got %0d extra, %0d missing expected 0", got_q.size(), exp_q.size()); else pass_n++;
    exp_q.delete();
    total_n++; if (done_n != 1 || err_n != 0)
      $display("FAIL all_done: got %0d done %0d err expected 1 0", done_n, err_n); else pass_n++;
  endtask

  task automatic test_errors();
    logic [7:0] e, g;
    clear_mem(); mem[0] = 8'd1;
    for (int i = 0; i < 32; i++) begin mem[1 + i] = 8'h20; exp_q.push_back(8'h20); end
    issue(0, 4'd0);
    run(300, 0);
    total_n++; if (!ok) $display("FAIL noterm_timeout: got busy expected idle"); else pass_n++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total_n++;
      if (g !== e) $display("FAIL noterm_byte: got %02h expected %02h", g, e); else pass_n++;
    end
    total_n++; if (got_q.size() + exp_q.size() != 0)
      $display("FAIL noterm_count: got %0d extra, %0d missing expected 0", got_q.size(), exp_q.size()); else pass_n++;
    exp_q.delete();
    total_n++; if (error_code !== 2'd2 || err_n != 1 || done_n != 0)
      $display("FAIL noterm_err: got code %0d pulses %0d done %0d expected 2 1 0", error_code, err_n, done_n); else pass_n++;
    mem[0] = 8'd0;
    issue(1, 4'd0);
    run(50, 0);
    total_n++; if (!ok || error_code !== 2'd3 || err_n != 1)
      $display("FAIL empty_err: got code %0d pulses %0d expected 3 1", error_code, err_n); else pass_n++;
    total_n++; if (got_q.size() != 0) $display("FAIL empty_writes: got %0d expected 0", got_q.size()); else pass_n++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, g;
    clear_mem(); mem[0] = 8'd7; load_str(0, "AT\r\n");
    issue(0, 4'd0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total_n++; if (tx_wr_en !== 1'b0) $display("FAIL rstmid_wr: got %b expected 0", tx_wr_en); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_n++;
    total_n++; if (error_code !== 2'd0) $display("FAIL rstmid_err: got %0d expected 0", error_code); else pass_n++;
    rst_n = 1'b1;
    expect_str("AT\r\n");
    issue(0, 4'd0);
    run(200, 0);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total_n++;
      if (g !== e) $display("FAIL rstmid_byte: got %02h expected %02h", g, e); else pass_n++;
    end
    total_n++; if (got_q.size() + exp_q.size() != 0)
      $display("FAIL rstmid_count: got %0d extra, %0d missing expected 0", got_q.size(), exp_q.size()); else pass_n++;
    exp_q.delete();
    total_n++; if (!ok || done_n != 1) $display("FAIL rstmid_done: got %0d expected 1", done_n); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_idx();
    test_stall();
    test_send_all();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
